// File: rtl/i2c_clock.sv
// I2C master SCL generator: open-drain (or push-pull) bus clock with clock
// stretching, multi-master low-phase alignment and a stuck-bus detector.
module i2c_clock #(
    parameter int COUNTER_WIDTH    = 9,
    parameter int COUNTER_END      = 500,
    parameter int COUNTER_HIGH     = 250,
    parameter int COUNTER_RISE     = 50,
    parameter int MULTI_MASTER     = 0,
    parameter int CLOCK_STRETCHING = 1,
    parameter int WAIT_WIDTH       = 19,
    parameter int WAIT_END         = 500000,
    parameter int PUSH_PULL        = 0
) (
    input  logic                     clk_in,
    input  logic                     rst_n,
    inout  wire                      scl,
    input  logic                     release_line,
    output logic                     bus_clear,
    output logic [COUNTER_WIDTH-1:0] counter
);

    localparam int STRETCH_POINT = COUNTER_HIGH + COUNTER_RISE / 2;

    localparam logic [COUNTER_WIDTH-1:0] C_STRETCH  = COUNTER_WIDTH'(STRETCH_POINT);
    localparam logic [COUNTER_WIDTH-1:0] C_HIGH     = COUNTER_WIDTH'(COUNTER_HIGH);
    localparam logic [COUNTER_WIDTH-1:0] C_LAST     = COUNTER_WIDTH'(COUNTER_END - 1);
    localparam logic [WAIT_WIDTH-1:0]    C_WAIT_END = WAIT_WIDTH'(WAIT_END);

    logic [COUNTER_WIDTH-1:0] r_counter;
    logic [WAIT_WIDTH-1:0]    r_stuck;

    logic w_driveLow;
    logic w_driveHigh;
    logic w_sclLow;
    logic w_hold;
    logic w_sync;

    // Reset must release the line even though the counter then sits in the low phase.
    assign w_driveLow  = rst_n && !release_line && (r_counter < C_HIGH);
    assign w_driveHigh = (PUSH_PULL != 0) && rst_n;
    assign scl         = w_driveLow ? 1'b0 : (w_driveHigh ? 1'b1 : 1'bz);

    // Only a definite 0 counts as low; a floating line is pulled up. Push-pull ignores the pin.
    assign w_sclLow = (PUSH_PULL == 0) && (scl === 1'b0);

    assign w_hold = (CLOCK_STRETCHING != 0) && (PUSH_PULL == 0) && w_sclLow
                    && (r_counter == C_STRETCH);
    assign w_sync = (MULTI_MASTER != 0) && (PUSH_PULL == 0) && w_sclLow
                    && (r_counter > C_STRETCH);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_counter <= '0;
        end else if (w_hold) begin
            r_counter <= r_counter;
        end else if (w_sync || (r_counter == C_LAST)) begin
            r_counter <= '0;
        end else begin
            r_counter <= r_counter + 1'b1;
        end
    end

    // Counts only lows that someone else is causing; saturates so bus_clear stays up.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_stuck <= '0;
        end else if (!w_sclLow || w_driveLow) begin
            r_stuck <= '0;
        end else if (r_stuck != C_WAIT_END) begin
            r_stuck <= r_stuck + 1'b1;
        end
    end

    assign bus_clear = (r_stuck == C_WAIT_END);
    assign counter   = r_counter;

endmodule

// File: tb/tb_i2c_clock.sv
// Scoreboard bench for i2c_clock: three instances (multi-master, default, push-pull)
// compared every cycle against a behavioural model driven by directed and random bus activity.
module tb_i2c_clock;

    localparam int CW      = 9;
    localparam int PERIOD  = 500;
    localparam int HIGH    = 250;
    localparam int RISE    = 50;
    localparam int STRETCH = HIGH + RISE / 2;
    localparam int WW      = 12;
    localparam int WEND    = 3000;
    localparam bit [2:0] P_MM = 3'b101;
    localparam bit [2:0] P_PP = 3'b100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       releaseLine = 1'b0;
    logic [2:0] extLow = 3'b000;

    tri1 scl0;
    tri1 scl1;
    tri1 scl2;
    logic [CW-1:0] cnt0, cnt1, cnt2;
    logic bc0, bc1, bc2;

    assign scl0 = extLow[0] ? 1'b0 : 1'bz;
    assign scl1 = extLow[1] ? 1'b0 : 1'bz;
    assign scl2 = extLow[2] ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_clock #(.COUNTER_WIDTH(CW), .COUNTER_END(PERIOD), .COUNTER_HIGH(HIGH), .COUNTER_RISE(RISE),
                .MULTI_MASTER(1), .CLOCK_STRETCHING(1), .WAIT_WIDTH(WW), .WAIT_END(WEND), .PUSH_PULL(0))
    dut0 (.clk_in(clk), .rst_n(rst_n), .scl(scl0), .release_line(releaseLine), .bus_clear(bc0), .counter(cnt0));

    i2c_clock #(.COUNTER_WIDTH(CW), .COUNTER_END(PERIOD), .COUNTER_HIGH(HIGH), .COUNTER_RISE(RISE),
                .MULTI_MASTER(0), .CLOCK_STRETCHING(1), .WAIT_WIDTH(WW), .WAIT_END(WEND), .PUSH_PULL(0))
    dut1 (.clk_in(clk), .rst_n(rst_n), .scl(scl1), .release_line(releaseLine), .bus_clear(bc1), .counter(cnt1));

    i2c_clock #(.COUNTER_WIDTH(CW), .COUNTER_END(PERIOD), .COUNTER_HIGH(HIGH), .COUNTER_RISE(RISE),
                .MULTI_MASTER(1), .CLOCK_STRETCHING(1), .WAIT_WIDTH(WW), .WAIT_END(WEND), .PUSH_PULL(1))
    dut2 (.clk_in(clk), .rst_n(rst_n), .scl(scl2), .release_line(releaseLine), .bus_clear(bc2), .counter(cnt2));

    typedef struct {
        int idx;
        int cnt;
        bit bc;
        bit chkScl;
        bit scl;
    } exp_t;

    exp_t sbq[$];
    int   nChecks = 0;
    int   nFails  = 0;

    function automatic int obsCnt(int i);
        if (i == 0) return int'(cnt0);
        if (i == 1) return int'(cnt1);
        return int'(cnt2);
    endfunction

    function automatic int obsBc(int i);
        if (i == 0) return int'(bc0);
        if (i == 1) return int'(bc1);
        return int'(bc2);
    endfunction

    function automatic int obsScl(int i);
        if (i == 0) return (scl0 === 1'b1) ? 1 : 0;
        if (i == 1) return (scl1 === 1'b1) ? 1 : 0;
        return (scl2 === 1'b1) ? 1 : 0;
    endfunction

    task automatic checkOutput(string name, int idx, int actual, int expected);
        nChecks++;
        if (actual != expected) begin
            nFails++;
            $display("[TB] FAIL %s dut%0d: got %0d, expected %0d at %0t", name, idx, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    // Reference model: one period of PERIOD cycles, low for the first HIGH of them;
    // a low bus freezes the count at the stretch point, and a multi-master low past
    // that point restarts the period. Stuck time counts lows this master is not making.
    int mCnt[3];
    int mStuck[3];
    int newCnt, newStuck;
    bit selfLow, busLow;
    exp_t e;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                mCnt[i]   = 0;
                mStuck[i] = 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                selfLow = !releaseLine && (mCnt[i] < HIGH);
                busLow  = !P_PP[i] && (extLow[i] || selfLow);
                if (busLow && mCnt[i] == STRETCH) newCnt = mCnt[i];
                else if (P_MM[i] && busLow && mCnt[i] > STRETCH) newCnt = 0;
                else newCnt = (mCnt[i] + 1) % PERIOD;
                if (busLow && !selfLow) newStuck = (mStuck[i] < WEND) ? mStuck[i] + 1 : WEND;
                else newStuck = 0;
                mCnt[i]   = newCnt;
                mStuck[i] = newStuck;
                selfLow   = !releaseLine && (newCnt < HIGH);
                e.idx    = i;
                e.cnt    = newCnt;
                e.bc     = (newStuck == WEND);
                e.chkScl = !(P_PP[i] && extLow[i]);
                e.scl    = !(selfLow || extLow[i]);
                sbq.push_back(e);
            end
        end
    end

    exp_t m;
    always @(posedge clk) begin
        #1;
        while (sbq.size() > 0) begin
            m = sbq.pop_front();
            checkOutput("counter", m.idx, obsCnt(m.idx), m.cnt);
            checkOutput("bus_clear", m.idx, obsBc(m.idx), int'(m.bc));
            if (m.chkScl) checkOutput("scl", m.idx, obsScl(m.idx), int'(m.scl));
        end
    end

    task automatic waitCount(int target);
        int k;
        k = 0;
        while (mCnt[0] != target && k < 3 * PERIOD) begin
            @(negedge clk);
            k++;
        end
        if (mCnt[0] != target) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL wait_count: reached %0d, expected %0d within bound", mCnt[0], target);
        end
    endtask

    // Reset must act without a clock edge: outputs are checked 1 time unit after rst_n falls.
    task automatic resetNow();
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput("rst_counter", i, obsCnt(i), 0);
            checkOutput("rst_bus_clear", i, obsBc(i), 0);
            if (!extLow[i]) checkOutput("rst_scl", i, obsScl(i), 1);
        end
        applyStimulus(3);
        rst_n = 1'b1;
    endtask

    initial begin
        applyStimulus(3);
        rst_n = 1'b1;
        $display("[TB] free-running periods");
        applyStimulus(1000);

        $display("[TB] slave stretch from counter 250");
        waitCount(HIGH);
        extLow = 3'b111;
        applyStimulus(125);
        extLow = 3'b000;
        applyStimulus(400);

        $display("[TB] external low at counter 400");
        waitCount(400);
        extLow = 3'b101;
        applyStimulus(1);
        extLow = 3'b000;
        applyStimulus(600);

        $display("[TB] release_line held high");
        releaseLine = 1'b1;
        applyStimulus(1000);

        $display("[TB] stuck bus timeout");
        extLow = 3'b111;
        applyStimulus(WEND + 5);
        extLow = 3'b000;
        applyStimulus(5);
        extLow = 3'b111;
        applyStimulus(WEND + 5);
        resetNow();
        extLow = 3'b000;
        releaseLine = 1'b0;
        applyStimulus(20);

        $display("[TB] reset mid-period");
        waitCount(300);
        resetNow();
        applyStimulus(10);
        waitCount(100);
        resetNow();
        applyStimulus(10);

        $display("[TB] random bus activity");
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 199) == 0) releaseLine = ~releaseLine;
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 59) == 0) extLow[i] = ~extLow[i];
            end
            applyStimulus(1);
        end
        extLow = 3'b000;
        releaseLine = 1'b0;
        applyStimulus(600);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
